// File: rtl/uart_rx_core_pkg.sv
`default_nettype none
// ============================================================================
// Module : uart_rx_core_pkg
// Brief  : Shared UART definitions: frame states, data width, divider
//          defaults for simulation and synthesis, parity helper.
// Rev    : 1.0  initial release
// ============================================================================
package uart_rx_core_pkg;

  // Data bits per frame (LSB first on the wire)
  localparam int DATA_BITS = 8;

  // Small divider values used in simulation (16 / 8 clk per bit)
  localparam int SIM_T_DIV_BIT    = 4;
  localparam int SIM_T_DIV_0      = 15;
  localparam int SIM_T_DIV_HALF_0 = 7;
  localparam int SIM_T_DIV_1      = 7;
  localparam int SIM_T_DIV_HALF_1 = 3;

  // Divider values for a 50 MHz clock (9600 / 19200 baud)
  localparam int SYN_T_DIV_BIT    = 13;
  localparam int SYN_T_DIV_0      = 5207;
  localparam int SYN_T_DIV_HALF_0 = 2603;
  localparam int SYN_T_DIV_1      = 2603;
  localparam int SYN_T_DIV_HALF_1 = 1301;

  // Frame states shared by receiver and transmitter
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } rx_state_e;

  // Even parity: the parity bit that makes the total count of ones even
  function automatic logic even_parity(input logic [DATA_BITS-1:0] data);
    return ^data;
  endfunction

endpackage
`default_nettype wire

// File: rtl/uart_baud_cnt.sv
`default_nettype none
// ============================================================================
// Module : uart_baud_cnt
// Brief  : Loadable bit-period divider. Counts 0..max, pulses tick while the
//          count equals max and wraps to 0 on the following clock. A high
//          clear holds the count at 0 so the next period starts cleanly.
// Rev    : 1.0  initial release
// ============================================================================
module uart_baud_cnt #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic             clear,
  input  logic [WIDTH-1:0] max,
  output logic             tick
);

  logic [WIDTH-1:0] cnt_q;
  logic [WIDTH-1:0] cnt_d;

  // Next count: wrap at max so the counter never leaves 0..max
  always_comb begin
    tick  = (cnt_q == max);
    cnt_d = cnt_q + 1'b1;
    if (clear || tick) begin
      cnt_d = '0;
    end
  end

  // Divider count register
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/uart_rx_core.sv
`default_nettype none
// ============================================================================
// Module : uart_rx_core
// Brief  : 8-bit UART receiver (start, 8 data LSB first, optional even
//          parity, 1 stop). Two-flop input synchronizer, falling-edge start
//          detection, mid-bit sampling with a per-frame latched baud select.
//          Optional feature macro: UART_RX_PARITY_EN (adds the parity bit,
//          the PARITY state and the parity_err output).
// Rev    : 1.0  initial release
// ============================================================================
module uart_rx_core
  import uart_rx_core_pkg::*;
#(
  parameter int                   T_DIV_BIT    = SIM_T_DIV_BIT,
  parameter logic [T_DIV_BIT-1:0] T_DIV_0      = T_DIV_BIT'(SIM_T_DIV_0),
  parameter logic [T_DIV_BIT-1:0] T_DIV_HALF_0 = T_DIV_BIT'(SIM_T_DIV_HALF_0),
  parameter logic [T_DIV_BIT-1:0] T_DIV_1      = T_DIV_BIT'(SIM_T_DIV_1),
  parameter logic [T_DIV_BIT-1:0] T_DIV_HALF_1 = T_DIV_BIT'(SIM_T_DIV_HALF_1)
) (
  input  logic                 clk,
  input  logic                 n_rst,
  input  logic                 baudrate,
  input  logic                 uart_rxd,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 frame_err,
`ifdef UART_RX_PARITY_EN
  output logic                 parity_err,
`endif
  output logic                 busy
);

  localparam logic [2:0] LAST_BIT = 3'(DATA_BITS - 1);

  // Input synchronizer and edge detector
  logic sync1_q, sync1_d;
  logic rxd_s_q, rxd_s_d;
  logic rxd_d_q, rxd_d_d;
  logic start_edge;

  // Frame state and datapath
  rx_state_e            state_q, state_d;
  logic [T_DIV_BIT-1:0] div_max_q, div_max_d;
  logic [T_DIV_BIT-1:0] half_max_q, half_max_d;
  logic [2:0]           bit_idx_q, bit_idx_d;
  logic [DATA_BITS-1:0] shreg_q, shreg_d;
  logic [DATA_BITS-1:0] rx_data_q, rx_data_d;
  logic                 rx_valid_q, rx_valid_d;
  logic                 frame_err_q, frame_err_d;
`ifdef UART_RX_PARITY_EN
  logic                 parity_bad_q, parity_bad_d;
  logic                 parity_err_q, parity_err_d;
`endif

  // Divider control
  logic                 cnt_clear;
  logic [T_DIV_BIT-1:0] cnt_max;
  logic                 cnt_tick;

  uart_baud_cnt #(
    .WIDTH (T_DIV_BIT)
  ) u_baud_cnt (
    .clk   (clk),
    .n_rst (n_rst),
    .clear (cnt_clear),
    .max   (cnt_max),
    .tick  (cnt_tick)
  );

  // Synchronizer chain and 1->0 detection on the synchronized line
  always_comb begin
    sync1_d    = uart_rxd;
    rxd_s_d    = sync1_q;
    rxd_d_d    = rxd_s_q;
    start_edge = rxd_d_q & ~rxd_s_q;
  end

  // Synchronizer flops idle high so reset never looks like a start bit
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      sync1_q <= 1'b1;
      rxd_s_q <= 1'b1;
      rxd_d_q <= 1'b1;
    end else begin
      sync1_q <= sync1_d;
      rxd_s_q <= rxd_s_d;
      rxd_d_q <= rxd_d_d;
    end
  end

  // Frame state register
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state, sampling and output pulses; every sample lands on a divider tick
  always_comb begin
    state_d      = state_q;
    div_max_d    = div_max_q;
    half_max_d   = half_max_q;
    bit_idx_d    = bit_idx_q;
    shreg_d      = shreg_q;
    rx_data_d    = rx_data_q;
    rx_valid_d   = 1'b0;
    frame_err_d  = 1'b0;
    cnt_clear    = 1'b0;
    cnt_max      = div_max_q;
`ifdef UART_RX_PARITY_EN
    parity_bad_d = parity_bad_q;
    parity_err_d = 1'b0;
`endif

    case (state_q)
      S_IDLE: begin
        // Hold the divider at 0 so START begins a clean half-bit count
        cnt_clear = 1'b1;
        if (start_edge) begin
          // Rate is frozen for the whole frame
          div_max_d  = baudrate ? T_DIV_1 : T_DIV_0;
          half_max_d = baudrate ? T_DIV_HALF_1 : T_DIV_HALF_0;
          state_d    = S_START;
        end
      end

      S_START: begin
        cnt_max = half_max_q;
        if (cnt_tick) begin
          if (!rxd_s_q) begin
            bit_idx_d = '0;
            state_d   = S_DATA;
          end else begin
            // Line went back high by mid-start: treat as a glitch
            state_d = S_IDLE;
          end
        end
      end

      S_DATA: begin
        if (cnt_tick) begin
          shreg_d   = {rxd_s_q, shreg_q[DATA_BITS-1:1]};
          bit_idx_d = bit_idx_q + 3'd1;
          if (bit_idx_q == LAST_BIT) begin
`ifdef UART_RX_PARITY_EN
            state_d = S_PARITY;
`else
            state_d = S_STOP;
`endif
          end
        end
      end

`ifdef UART_RX_PARITY_EN
      S_PARITY: begin
        if (cnt_tick) begin
          parity_bad_d = even_parity(shreg_q) ^ rxd_s_q;
          state_d      = S_STOP;
        end
      end
`endif

      S_STOP: begin
        if (cnt_tick) begin
          // Leave at mid-stop so a back-to-back start edge is not missed
          state_d = S_IDLE;
`ifdef UART_RX_PARITY_EN
          parity_err_d = parity_bad_q;
          if (rxd_s_q && !parity_bad_q) begin
            rx_data_d  = shreg_q;
            rx_valid_d = 1'b1;
          end
`else
          if (rxd_s_q) begin
            rx_data_d  = shreg_q;
            rx_valid_d = 1'b1;
          end
`endif
          if (!rxd_s_q) begin
            frame_err_d = 1'b1;
          end
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Datapath registers and registered output pulses
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      div_max_q    <= T_DIV_0;
      half_max_q   <= T_DIV_HALF_0;
      bit_idx_q    <= '0;
      shreg_q      <= '0;
      rx_data_q    <= '0;
      rx_valid_q   <= 1'b0;
      frame_err_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_bad_q <= 1'b0;
      parity_err_q <= 1'b0;
`endif
    end else begin
      div_max_q    <= div_max_d;
      half_max_q   <= half_max_d;
      bit_idx_q    <= bit_idx_d;
      shreg_q      <= shreg_d;
      rx_data_q    <= rx_data_d;
      rx_valid_q   <= rx_valid_d;
      frame_err_q  <= frame_err_d;
`ifdef UART_RX_PARITY_EN
      parity_bad_q <= parity_bad_d;
      parity_err_q <= parity_err_d;
`endif
    end
  end

  assign rx_data    = rx_data_q;
  assign rx_valid   = rx_valid_q;
  assign frame_err  = frame_err_q;
  assign busy       = (state_q != S_IDLE);
`ifdef UART_RX_PARITY_EN
  assign parity_err = parity_err_q;
`endif

endmodule
`default_nettype wire
